pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/patdet_pkg.sv | 18 +
 rtl/patdet_sat_cnt.sv | 22 ++
 rtl/pattern_detector.sv | 108 ++++++++++
 tb/tb_pattern_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/patdet_pkg.sv
// Shared types and defaults for the serial pattern detector.
package patdet_pkg;

  localparam int PATDET_W_DEF     = 6;
  localparam int PATDET_CNT_W_DEF = 8;

  // FILL: collecting a fresh window of bits; HUNT: every valid bit is compared
  typedef enum logic {
    FILL = 1'b0,
    HUNT = 1'b1
  } patdet_state_e;

  // Width of a counter able to hold the value n
  function automatic int patdet_cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/patdet_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module patdet_sat_cnt
  import patdet_pkg::*;
#(
  parameter int CNT_W = PATDET_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count requests, holding at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with overlapping/non-overlapping match modes and a
// loadable pattern. The match counter is only built when PATDET_CNT_EN is
// defined; otherwise match_cnt is tied to zero.
module pattern_detector
  import patdet_pkg::*;
#(
  parameter int             W       = PATDET_W_DEF,
  parameter int             CNT_W   = PATDET_CNT_W_DEF,
  parameter logic [W-1:0]   PAT_RST = W'(6'b101011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [W-1:0]     pat_i,
  input  logic             overlap,
  output logic             found,
  output logic [W-1:0]     s,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = patdet_cnt_bits(W);

  patdet_state_e state, state_n;
  logic [FW-1:0] fill_cnt, fill_n;
  logic [W-1:0]  pattern, pattern_n;
  logic [W-1:0]  s_n;
  logic [W-1:0]  shifted;
  logic          last_fill;
  logic          match;

  assign shifted   = {s[W-2:0], din};
  assign last_fill = (fill_cnt == FW'(W - 1));
  assign armed     = (state == HUNT);

  // State, window, pattern and the registered match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      fill_cnt <= '0;
      pattern  <= PAT_RST;
      s        <= '0;
      found    <= 1'b0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_n;
      pattern  <= pattern_n;
      s        <= s_n;
      found    <= match;
    end
  end

  // Next-state, shift and match decode; pat_load wins over din_valid
  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    pattern_n = pattern;
    s_n       = s;
    match     = 1'b0;
    if (pat_load) begin
      pattern_n = pat_i;
      s_n       = '0;
      fill_n    = '0;
      state_n   = FILL;
    end else if (din_valid) begin
      s_n = shifted;
      unique case (state)
        FILL: begin
          if (last_fill) begin
            // The W-th fill bit completes a window and is compared at once
            match   = (shifted == pattern);
            fill_n  = '0;
            state_n = (match && !overlap) ? FILL : HUNT;
          end else begin
            fill_n = fill_cnt + FW'(1);
          end
        end
        HUNT: begin
          match = (shifted == pattern);
          if (match && !overlap) begin
            fill_n  = '0;
            state_n = FILL;
          end
        end
        default: begin
          state_n = FILL;
          fill_n  = '0;
        end
      endcase
    end
  end

`ifdef PATDET_CNT_EN
  patdet_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .cnt  (match_cnt)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector (W=6). A second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_pattern_detector;

  localparam int W = 6;
`ifdef PATDET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, din_valid, din, pat_load, overlap;
  logic [W-1:0] pat_i;
  logic         found, armed, found2, armed2;
  logic [W-1:0] s, s2;
  logic [7:0]   match_cnt;
  logic [1:0]   match_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model: window, valid bits since last clear, pattern, counts
  logic [W-1:0] m_s, m_pat;
  int           m_n;
  logic         m_found;
  int           m_cnt, m_cnt2;

  pattern_detector #(.W(W), .CNT_W(8), .PAT_RST(6'b101011)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_i(pat_i), .overlap(overlap),
    .found(found), .s(s), .armed(armed), .match_cnt(match_cnt));

  pattern_detector #(.W(W), .CNT_W(2), .PAT_RST(6'b101011)) dut_c2 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_i(pat_i), .overlap(overlap),
    .found(found2), .s(s2), .armed(armed2), .match_cnt(match_cnt2));

  always #5 clk = ~clk;

  function automatic int exp_cnt(input int c);
    return CNT_EN ? c : 0;
  endfunction

  // Drive one clock of inputs and advance the model past that edge
  task automatic tick(input logic r, input logic l, input logic [W-1:0] p,
                      input logic v, input logic d, input logic ov);
    reset = r; pat_load = l; pat_i = p; din_valid = v; din = d; overlap = ov;
    @(posedge clk);
    #1;
    m_found = 1'b0;
    if (r) begin
      m_s = '0; m_n = 0; m_pat = 6'b101011; m_cnt = 0; m_cnt2 = 0;
    end else if (l) begin
      m_pat = p; m_s = '0; m_n = 0;
    end else if (v) begin
      m_s = {m_s[W-2:0], d};
      m_n = m_n + 1;
      if (m_n >= W && m_s == m_pat) begin
        m_found = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
        if (!ov) m_n = 0;
      end
    end
    reset = 1'b0; pat_load = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick(1, 0, '0, 0, 0, 1);
    tick(1, 0, '0, 1, 1, 1);
    checks++;
    if (found !== 1'b0 || armed !== 1'b0 || s !== '0) begin
      errors++; $display("FAIL reset_outputs found=%b armed=%b s=%b exp 0 0 000000", found, armed, s);
    end
    checks++;
    if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", match_cnt, match_cnt2);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] bits;
    bits = 6'b101011;
    tick(1, 0, '0, 0, 0, 1);
    for (int i = W - 1; i >= 0; i--) begin
      tick(0, 0, '0, 1, bits[i], 1);
      checks++;
      if (found !== m_found || armed !== (m_n >= W) || s !== m_s) begin
        errors++;
        $display("FAIL basic_bit%0d found=%b armed=%b s=%b exp %b %b %b", W - i, found, armed, s, m_found, m_n >= W, m_s);
      end
    end
    checks++;
    if (found !== 1'b1 || armed !== 1'b1 || match_cnt !== 8'(exp_cnt(1))) begin
      errors++; $display("FAIL basic_sixth found=%b armed=%b cnt=%0d exp 1 1 %0d", found, armed, match_cnt, exp_cnt(1));
    end
    tick(0, 0, '0, 0, 0, 1);
    checks++;
    if (found !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_width found=%b exp 0", found);
    end
  endtask

  task automatic test_overlap;
    logic [10:0] stream;
    int pulses;
    stream = 11'b10101101011;
    for (int ov = 1; ov >= 0; ov--) begin
      pulses = 0;
      tick(1, 0, '0, 0, 0, 1'(ov));
      for (int i = 10; i >= 0; i--) begin
        tick(0, 0, '0, 1, stream[i], 1'(ov));
        if (found === 1'b1) pulses++;
        checks++;
        if (found !== m_found || armed !== (m_n >= W)) begin
          errors++; $display("FAIL overlap%0d_bit%0d found=%b armed=%b exp %b %b", ov, 11 - i, found, armed, m_found, m_n >= W);
        end
        if (i == 5) begin
          checks++;
          if (armed !== 1'(ov)) begin
            errors++; $display("FAIL overlap%0d_armed_after6 got %b exp %0d", ov, armed, ov);
          end
        end
      end
      checks++;
      if (pulses != (ov ? 2 : 1) || match_cnt !== 8'(exp_cnt(ov ? 2 : 1))) begin
        errors++; $display("FAIL overlap%0d_total pulses=%0d cnt=%0d exp %0d %0d", ov, pulses, match_cnt, ov ? 2 : 1, exp_cnt(ov ? 2 : 1));
      end
    end
  endtask

  task automatic test_gaps;
    logic [W-1:0] bits, held;
    int gap;
    bits = 6'b101011;
    tick(1, 0, '0, 0, 0, 1);
    for (int i = W - 1; i >= 0; i--) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        held = s;
        tick(0, 0, '0, 0, 1'($urandom), 1);
        checks++;
        if (s !== held || found !== 1'b0) begin
          errors++; $display("FAIL gaps_hold s=%b found=%b exp %b 0", s, found, held);
        end
      end
      tick(0, 0, '0, 1, bits[i], 1);
      checks++;
      if (found !== (i == 0) || s !== m_s) begin
        errors++; $display("FAIL gaps_bit%0d found=%b s=%b exp %b %b", W - i, found, s, i == 0, m_s);
      end
    end
  endtask

  task automatic test_reload;
    tick(1, 0, '0, 0, 0, 1);
    tick(0, 0, '0, 1, 1, 1);
    tick(0, 0, '0, 1, 0, 1);
    tick(0, 0, '0, 1, 1, 1);
    tick(0, 1, 6'b111111, 1, 1, 1);
    checks++;
    if (s !== 6'b000000 || found !== 1'b0 || armed !== 1'b0) begin
      errors++; $display("FAIL reload_clear s=%b found=%b armed=%b exp 000000 0 0", s, found, armed);
    end
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, '0, 1, 1, 1);
      checks++;
      if (found !== (i >= 6) || found !== m_found) begin
        errors++; $display("FAIL reload_one%0d found=%b exp %b", i, found, i >= 6);
      end
    end
  endtask

  task automatic test_midreset;
    logic [4:0] bits;
    bits = 5'b10101;
    tick(1, 0, '0, 0, 0, 1);
    for (int i = 4; i >= 0; i--) tick(0, 0, '0, 1, bits[i], 1);
    tick(1, 0, '0, 1, 1, 1);
    tick(0, 0, '0, 1, 1, 1);
    checks++;
    if (found !== 1'b0 || s !== 6'b000001 || armed !== 1'b0) begin
      errors++; $display("FAIL midreset found=%b s=%b armed=%b exp 0 000001 0", found, s, armed);
    end
  endtask

  task automatic test_saturation;
    tick(1, 0, '0, 0, 0, 1);
    tick(0, 1, 6'b111111, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, '0, 1, 1, 1);
      checks++;
      if (found2 !== found || found2 !== (i >= 6)) begin
        errors++; $display("FAIL sat_found%0d got %b exp %b", i, found2, i >= 6);
      end
    end
    checks++;
    if (match_cnt2 !== 2'(exp_cnt(3)) || match_cnt !== 8'(exp_cnt(5))) begin
      errors++; $display("FAIL sat_cnt got %0d/%0d exp %0d/%0d", match_cnt2, match_cnt, exp_cnt(3), exp_cnt(5));
    end
  endtask

  task automatic test_random;
    logic r, l, v, d, ov;
    logic [W-1:0] p;
    tick(1, 0, '0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom);
      ov = ($urandom_range(0, 2) != 0);
      p  = ($urandom_range(0, 1) != 0) ? 6'b101011 : 6'($urandom_range(0, 7));
      tick(r, l, p, v, d, ov);
      checks++;
      if (found !== m_found || s !== m_s || armed !== (m_n >= W) ||
          match_cnt !== 8'(exp_cnt(m_cnt)) || match_cnt2 !== 2'(exp_cnt(m_cnt2))) begin
        errors++;
        $display("FAIL random_cyc%0d found=%b s=%b armed=%b cnt=%0d cnt2=%0d exp %b %b %b %0d %0d", i, found, s, armed, match_cnt, match_cnt2, m_found, m_s, m_n >= W, exp_cnt(m_cnt), exp_cnt(m_cnt2));
      end
    end
  endtask

  initial begin
    reset = 1'b1; din_valid = 1'b0; din = 1'b0; pat_load = 1'b0; overlap = 1'b1; pat_i = '0;
    m_s = '0; m_pat = 6'b101011; m_n = 0; m_found = 1'b0; m_cnt = 0; m_cnt2 = 0;
    test_reset;
    test_basic;
    test_overlap;
    test_gaps;
    test_reload;
    test_midreset;
    test_saturation;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
